te_stream_ctrl: RTL and testbench

- Frame-level controller and pipeline sequencer for the transmission-estimation stage.
- Consumes the per-pixel min(Pc/Ac) stream (Q0.16), scales it by ω, and applies T(x) = ONE − ω·min with lower clamp T0.
- Emits transmission values with sof/eof framing and valid/ready backpressure.
- Owns double-buffered ω/T0 configuration (switched only at frame start), pixel counting, and framing-error detection.

---
 rtl/te_stream_ctrl.sv | 178 +++++++++++++++++
 tb/tb_te_stream_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/te_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : te_stream_ctrl
// Function : Transmission-estimation stream sequencer, T = max(T0, 1 - w*min)
// Revision : 1.0 - initial release
// ============================================================================
module te_stream_ctrl #(
   parameter int IMG_W     = 512,
   parameter int IMG_H     = 512,
   parameter int OMEGA_RST = 62259,
   parameter int T0_RST    = 21299
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_we,
   input  logic [15:0] cfg_omega,
   input  logic [15:0] cfg_t0,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [15:0] s_data,
   input  logic        s_sof,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [15:0] m_data,
   output logic        m_sof,
   output logic        m_eof,
   output logic        busy,
   output logic        err_sof
);

   localparam int              C_NPIX     = IMG_W * IMG_H;
   localparam int              C_CW       = $clog2(C_NPIX);
   localparam logic [C_CW-1:0] C_LAST_PIX = C_CW'(C_NPIX - 1);
   localparam logic [C_CW-1:0] C_ONE_PIX  = C_CW'(1);
   localparam logic [15:0]     C_OMEGA0   = 16'(OMEGA_RST);
   localparam logic [15:0]     C_T00      = 16'(T0_RST);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [C_CW-1:0]   pix_q, pix_d;
   logic              err_q, err_d;
   logic [15:0]       omega_pend_q, t0_pend_q, omega_act_q, t0_act_q;
   logic              v1_q, v1_d, sof1_q, sof1_d, eof1_q, eof1_d;
   logic [15:0]       scaled1_q, scaled1_d;
   logic              mv_q, mv_d, msof_q, msof_d, meof_q, meof_d;
   logic [15:0]       md_q, md_d;

   logic              w_en, w_acc, w_sof_acc, w_fwd, w_tag_eof;
   logic [15:0]       w_omega_new, w_t0_new, w_omega_use, w_scaled, w_max_t, w_t;

   assign w_en      = !mv_q || m_ready;
   assign w_acc     = s_valid && w_en;
   assign w_sof_acc = w_acc && s_sof;

   // A coincident cfg write bypasses the pending registers on a frame start.
   assign w_omega_new = cfg_we ? cfg_omega : omega_pend_q;
   assign w_t0_new    = cfg_we ? cfg_t0    : t0_pend_q;
   assign w_omega_use = w_sof_acc ? w_omega_new : omega_act_q;
   assign w_scaled    = 16'(({16'd0, w_omega_use} * {16'd0, s_data}) >> 16);

   // Stage-2 uses the active T0; it can only change when stage 1 is refilled.
   assign w_max_t = 16'hFFFF - t0_act_q;
   assign w_t     = (scaled1_q > w_max_t) ? t0_act_q : (16'hFFFF - scaled1_q);

   always_comb begin
      state_d   = state_q;
      pix_d     = pix_q;
      err_d     = err_q;
      w_fwd     = 1'b0;
      w_tag_eof = 1'b0;
      if (w_acc) begin
         case (state_q)
            ST_IDLE: begin
               if (s_sof) begin
                  w_fwd   = 1'b1;
                  pix_d   = C_ONE_PIX;
                  state_d = ST_RUN;
               end else begin
                  err_d = 1'b1;
               end
            end
            ST_RUN: begin
               w_fwd = 1'b1;
               if (s_sof) begin
                  err_d = 1'b1;
                  pix_d = C_ONE_PIX;
               end else if (pix_q == C_LAST_PIX) begin
                  w_tag_eof = 1'b1;
                  pix_d     = '0;
                  state_d   = ST_IDLE;
               end else begin
                  pix_d = pix_q + C_ONE_PIX;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      v1_d      = v1_q;
      sof1_d    = sof1_q;
      eof1_d    = eof1_q;
      scaled1_d = scaled1_q;
      mv_d      = mv_q;
      msof_d    = msof_q;
      meof_d    = meof_q;
      md_d      = md_q;
      if (w_en) begin
         v1_d   = w_acc && w_fwd;
         sof1_d = w_acc && w_fwd && s_sof;
         eof1_d = w_tag_eof;
         if (w_acc && w_fwd) begin
            scaled1_d = w_scaled;
         end
         mv_d   = v1_q;
         msof_d = v1_q && sof1_q;
         meof_d = v1_q && eof1_q;
         if (v1_q) begin
            md_d = w_t;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         pix_q        <= '0;
         err_q        <= 1'b0;
         omega_pend_q <= C_OMEGA0;
         t0_pend_q    <= C_T00;
         omega_act_q  <= C_OMEGA0;
         t0_act_q     <= C_T00;
         v1_q         <= 1'b0;
         sof1_q       <= 1'b0;
         eof1_q       <= 1'b0;
         scaled1_q    <= '0;
         mv_q         <= 1'b0;
         msof_q       <= 1'b0;
         meof_q       <= 1'b0;
         md_q         <= '0;
      end else begin
         state_q   <= state_d;
         pix_q     <= pix_d;
         err_q     <= err_d;
         v1_q      <= v1_d;
         sof1_q    <= sof1_d;
         eof1_q    <= eof1_d;
         scaled1_q <= scaled1_d;
         mv_q      <= mv_d;
         msof_q    <= msof_d;
         meof_q    <= meof_d;
         md_q      <= md_d;
         if (cfg_we) begin
            omega_pend_q <= cfg_omega;
            t0_pend_q    <= cfg_t0;
         end
         if (w_sof_acc) begin
            omega_act_q <= w_omega_new;
            t0_act_q    <= w_t0_new;
         end
      end
   end

   assign s_ready = w_en;
   assign m_valid = mv_q;
   assign m_data  = md_q;
   assign m_sof   = msof_q;
   assign m_eof   = meof_q;
   assign err_sof = err_q;
   assign busy    = (state_q == ST_RUN) || v1_q || mv_q;

endmodule
`default_nettype wire

// File: tb/tb_te_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_te_stream_ctrl
// Function : Self-checking bench for te_stream_ctrl (4x2 frame build)
// Revision : 1.0 - initial release
// ============================================================================
module tb_te_stream_ctrl;

   localparam int W = 4;
   localparam int H = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_we = 1'b0;
   logic [15:0] cfg_omega = 16'd62259;
   logic [15:0] cfg_t0 = 16'd21299;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [15:0] s_data = '0;
   logic        s_sof = 1'b0;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [15:0] m_data;
   logic        m_sof, m_eof, busy, err_sof;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   te_stream_ctrl #(.IMG_W(W), .IMG_H(H), .OMEGA_RST(62259), .T0_RST(21299)) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_omega(cfg_omega), .cfg_t0(cfg_t0),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_sof(m_sof), .m_eof(m_eof), .busy(busy), .err_sof(err_sof)
   );

   typedef struct packed {
      logic [15:0] data;
      logic        sof;
      logic        eof;
   } beat_t;

   // Behavioural model: frame bookkeeping plus a queue of beats owed downstream.
   beat_t       exp_q[$];
   bit          mdl_in_frame = 0;
   int          mdl_cnt = 0;
   int          mdl_om_p = 62259, mdl_t0_p = 21299, mdl_om_a = 62259, mdl_t0_a = 21299;
   bit          mdl_err = 0;
   int          out_count = 0;
   logic [15:0] out_data[64];
   bit          out_sof[64], out_eof[64];
   bit          prev_stall = 0;
   logic [15:0] prev_data;
   bit          prev_sof, prev_eof;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int t_of(input int om, input int t0, input int d);
      longint sc;
      int     t;
      sc = (longint'(om) * longint'(d)) / 65536;
      t  = 65535 - int'(sc);
      if (t < t0) t = t0;
      return t;
   endfunction

   task automatic model_reset();
      mdl_in_frame = 0;
      mdl_cnt      = 0;
      mdl_om_p     = 62259;
      mdl_t0_p     = 21299;
      mdl_om_a     = 62259;
      mdl_t0_a     = 21299;
      mdl_err      = 0;
      prev_stall   = 0;
      exp_q.delete();
   endtask

   task automatic model_accept(input int d, input bit sof);
      beat_t b;
      if (sof) begin
         if (mdl_in_frame) mdl_err = 1;
         mdl_om_a     = cfg_we ? int'(cfg_omega) : mdl_om_p;
         mdl_t0_a     = cfg_we ? int'(cfg_t0) : mdl_t0_p;
         mdl_in_frame = 1;
         mdl_cnt      = 1;
         b.data = 16'(t_of(mdl_om_a, mdl_t0_a, d));
         b.sof  = 1'b1;
         b.eof  = 1'b0;
         exp_q.push_back(b);
      end else if (!mdl_in_frame) begin
         mdl_err = 1;
      end else begin
         mdl_cnt++;
         b.data = 16'(t_of(mdl_om_a, mdl_t0_a, d));
         b.sof  = 1'b0;
         b.eof  = (mdl_cnt == W * H);
         exp_q.push_back(b);
         if (b.eof) begin
            mdl_in_frame = 0;
            mdl_cnt      = 0;
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_m_valid", m_valid, 0);
         chk("rst_m_data", m_data, 0);
         chk("rst_m_sof", m_sof, 0);
         chk("rst_m_eof", m_eof, 0);
         chk("rst_err_sof", err_sof, 0);
         chk("rst_busy", busy, 0);
         model_reset();
      end else begin
         chk("s_ready", s_ready, !m_valid || m_ready);
         chk("err_sof", err_sof, mdl_err);
         chk("busy", busy, mdl_in_frame || (exp_q.size() > 0));
         if (prev_stall) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, prev_data);
            chk("stall_sof", m_sof, prev_sof);
            chk("stall_eof", m_eof, prev_eof);
         end
         if (m_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got data %0d expected no beat at %0t", m_data, $time);
            end else begin
               chk("out_data", m_data, exp_q[0].data);
               chk("out_sof", m_sof, exp_q[0].sof);
               chk("out_eof", m_eof, exp_q[0].eof);
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_sof   = m_sof;
         prev_eof   = m_eof;
         if (m_valid && m_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (out_count < 64) begin
               out_data[out_count] = m_data;
               out_sof[out_count]  = m_sof;
               out_eof[out_count]  = m_eof;
            end
            out_count++;
         end
         if (s_valid && s_ready) model_accept(int'(s_data), s_sof);
         if (cfg_we) begin
            mdl_om_p = int'(cfg_omega);
            mdl_t0_p = int'(cfg_t0);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [15:0] d, input bit sof);
      bit a;
      int t;
      a = 0;
      t = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_sof   = sof;
      while (!a && t < 50) begin
         @(negedge clk);
         a = s_ready;
         @(posedge clk);
         #1;
         t++;
      end
      if (!a) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no accept expected accept of %0d", d);
      end
      s_valid = 1'b0;
      s_sof   = 1'b0;
   endtask

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
   end

   initial begin
      cyc(3);
      rst = 1'b0;
      cyc(2);

      // Frame A: latency, clamp, full framing
      send(16'd32768, 1);
      #2;
      chk("lat_n1_valid", m_valid, 0);
      @(posedge clk);
      #1;
      chk("lat_n2_valid", m_valid, 1);
      chk("lat_n2_data", m_data, 34406);
      chk("lat_n2_sof", m_sof, 1);
      send(16'd65535, 0);
      send(16'd0, 0);
      send(16'd100, 0);
      send(16'd30000, 0);
      send(16'd50000, 0);
      send(16'd12345, 0);
      send(16'd65000, 0);
      cyc(5);
      chk("A_count", out_count, 8);
      chk("A_clamp", out_data[1], 21299);
      chk("A_zero", out_data[2], 65535);
      for (int i = 0; i < 8; i++) begin
         chk("A_sof_pos", out_sof[i], (i == 0));
         chk("A_eof_pos", out_eof[i], (i == 7));
      end
      chk("A_busy_idle", busy, 0);
      chk("A_err", err_sof, 0);

      // Beat without sof while idle is dropped
      send(16'd1234, 0);
      cyc(4);
      chk("drop_count", out_count, 8);
      chk("drop_err", err_sof, 1);
      chk("drop_valid", m_valid, 0);

      // Frame B: backpressure with mid-frame config write
      fork
         begin
            send(16'd1000, 1);
            send(16'd20000, 0);
            send(16'd40000, 0);
            send(16'd65535, 0);
            cfg_we    = 1'b1;
            cfg_omega = 16'd32768;
            cyc(1);
            cfg_we = 1'b0;
            send(16'd32768, 0);
            send(16'd32768, 0);
            send(16'd5, 0);
            send(16'd60000, 0);
         end
         begin
            for (int i = 0; i < 40; i++) begin
               m_ready = (i % 3 == 0);
               cyc(1);
            end
            m_ready = 1'b1;
         end
      join
      cyc(6);
      chk("B_count", out_count, 16);
      chk("B_old_omega0", out_data[12], 34406);
      chk("B_old_omega1", out_data[13], 34406);
      chk("B_eof", out_eof[15], 1);

      // Frame C uses new omega, truncated by a mid-frame sof starting frame D
      send(16'd32768, 1);
      send(16'd10, 0);
      send(16'd20, 0);
      send(16'd40000, 1);
      for (int i = 1; i < 8; i++) send(16'(i * 1000), 0);
      cyc(6);
      chk("C_new_omega", out_data[16], 49151);
      chk("C_d10", out_data[17], 65530);
      chk("D_first", out_data[19], 45535);
      chk("D_sof", out_sof[19], 1);
      for (int i = 16; i < 19; i++) chk("C_no_eof", out_eof[i], 0);
      chk("D_eof", out_eof[26], 1);
      chk("D_count", out_count, 27);
      chk("D_err", err_sof, 1);
      chk("drain_empty", exp_q.size(), 0);

      // Asynchronous reset while streaming
      send(16'd100, 1);
      send(16'd200, 0);
      s_valid = 1'b1;
      s_data  = 16'd300;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", m_valid, 0);
      chk("arst_data", m_data, 0);
      chk("arst_sof", m_sof, 0);
      chk("arst_eof", m_eof, 0);
      chk("arst_err", err_sof, 0);
      chk("arst_busy", busy, 0);
      s_valid = 1'b0;
      cyc(3);
      rst = 1'b0;
      cyc(4);
      chk("post_rst_valid", m_valid, 0);
      chk("post_rst_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
